// File: rtl/counter_sequencer.sv
// Bounded, restartable up-counter sequencer: one-shot or periodic counts from 0 to a latched period.
// Optional build macro COUNTER_SEQUENCER_PAUSE_EN adds a pause input that freezes counting in RUN.
module counter_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic             stop,
  input  logic             mode_reload,
`ifdef COUNTER_SEQUENCER_PAUSE_EN
  input  logic             pause,
`endif
  input  logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             tc,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] q_r, q_s;
  logic [WIDTH-1:0] period_r, period_s;
  logic             mode_r, mode_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             err_r, err_s;
  logic             tc_s;
  logic             pause_s;

`ifdef COUNTER_SEQUENCER_PAUSE_EN
  assign pause_s = pause;
`else
  assign pause_s = 1'b0;
`endif

  assign tc_s = (state_r == RUN) && (q_r == period_r);

  // Next-state and next-output logic; stop outranks pause, reload and completion in RUN
  always_comb begin
    state_s  = state_r;
    q_s      = q_r;
    period_s = period_r;
    mode_s   = mode_r;
    busy_s   = 1'b0;
    done_s   = 1'b0;
    err_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (start && !stop) begin
          if (period != {WIDTH{1'b0}}) begin
            state_s  = RUN;
            period_s = period;
            mode_s   = mode_reload;
            q_s      = {WIDTH{1'b0}};
            busy_s   = 1'b1;
          end else begin
            err_s = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (stop) begin
          state_s = IDLE;
        end else if (pause_s) begin
          busy_s = 1'b1;
        end else if (tc_s) begin
          if (mode_r) begin
            q_s    = {WIDTH{1'b0}};
            busy_s = 1'b1;
          end else begin
            state_s = DONE;
            done_s  = 1'b1;
          end
        end else begin
          q_s    = q_r + {{(WIDTH-1){1'b0}}, 1'b1};
          busy_s = 1'b1;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and registered outputs with synchronous clear
  always_ff @(posedge clk) begin
    if (clear) begin
      state_r  <= IDLE;
      q_r      <= {WIDTH{1'b0}};
      period_r <= {WIDTH{1'b0}};
      mode_r   <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      state_r  <= state_s;
      q_r      <= q_s;
      period_r <= period_s;
      mode_r   <= mode_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
      err_r    <= err_s;
    end
  end

  assign q    = q_r;
  assign busy = busy_r;
  assign done = done_r;
  assign err  = err_r;
  assign tc   = tc_s;

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer: per-cycle compare against a behavioural model
// plus hand-computed literal expectations at key points of each scenario.
module tb_counter_sequencer;
  localparam int W = 4;

  logic         clk;
  logic         clear;
  logic         start;
  logic         stop;
  logic         mode_reload;
  logic         pause;
  logic [W-1:0] period;
  logic [W-1:0] q;
  logic         busy;
  logic         tc;
  logic         done;
  logic         err;

  int checks;
  int errors;
  bit cmp_en;

  // model: "running" flag, current count, latched terminal, reload flag, pulses
  bit m_active;
  int m_q;
  int m_term;
  bit m_periodic;
  bit m_done;
  bit m_err;

  counter_sequencer #(.WIDTH(W)) dut (
    .clk         (clk),
    .clear       (clear),
    .start       (start),
    .stop        (stop),
    .mode_reload (mode_reload),
`ifdef COUNTER_SEQUENCER_PAUSE_EN
    .pause       (pause),
`endif
    .period      (period),
    .q           (q),
    .busy        (busy),
    .tc          (tc),
    .done        (done),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model advanced on each rising edge from the sampled commands
  always @(posedge clk) begin
    bit was_done;
    if (clear) begin
      m_active = 1'b0; m_q = 0; m_term = 0; m_periodic = 1'b0;
      m_done = 1'b0; m_err = 1'b0;
    end else begin
      was_done = m_done;
      m_done = 1'b0;
      m_err  = 1'b0;
      if (m_active) begin
        if (stop) m_active = 1'b0;
        else if (pause) m_active = 1'b1;
        else if (m_q == m_term) begin
          if (m_periodic) m_q = 0;
          else begin m_active = 1'b0; m_done = 1'b1; end
        end else m_q = m_q + 1;
      end else if (!was_done && start && !stop) begin
        if (period == 0) m_err = 1'b1;
        else begin
          m_active = 1'b1; m_q = 0; m_term = int'(period); m_periodic = mode_reload;
        end
      end
    end
  end

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, mid-cycle
  always @(negedge clk) begin
    if (cmp_en) begin
      cmp("model_q",    int'(q),    m_q);
      cmp("model_busy", int'(busy), int'(m_active));
      cmp("model_tc",   int'(tc),   int'(m_active && (m_q == m_term)));
      cmp("model_done", int'(done), int'(m_done));
      cmp("model_err",  int'(err),  int'(m_err));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    checks = 0; errors = 0; cmp_en = 1'b0;
    clear = 1'b1; start = 1'b0; stop = 1'b0; mode_reload = 1'b0; pause = 1'b0;
    period = '0;
    cyc(); cyc();
    cmp("rst_q", int'(q), 0);
    cmp("rst_busy", int'(busy), 0);
    cmp("rst_done", int'(done), 0);
    clear = 1'b0;
    cmp_en = 1'b1;

    // one-shot period 5; mid-run start/period change must be ignored
    period = 4'd5; mode_reload = 1'b0; start = 1'b1;
    cyc(); start = 1'b0;
    cmp("os_q0", int'(q), 0);
    cmp("os_busy0", int'(busy), 1);
    for (int i = 1; i <= 5; i++) begin
      if (i == 2) begin start = 1'b1; period = 4'd2; end
      cyc();
      cmp("os_q", int'(q), i);
      cmp("os_tc", int'(tc), (i == 5) ? 1 : 0);
    end
    cyc();
    cmp("os_done", int'(done), 1);
    cmp("os_done_q", int'(q), 5);
    cmp("os_done_busy", int'(busy), 0);
    cyc();
    cmp("os_idle_busy", int'(busy), 0);
    cmp("os_idle_done", int'(done), 0);
    cmp("os_idle_q", int'(q), 5);
    start = 1'b0;

    // periodic period 3, stop at q=2
    period = 4'd3; mode_reload = 1'b1; start = 1'b1;
    cyc(); start = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      cmp("per_q", int'(q), i % 4);
      cmp("per_tc", int'(tc), ((i % 4) == 3) ? 1 : 0);
    end
    stop = 1'b1;
    cyc(); stop = 1'b0;
    cmp("stop_q", int'(q), 2);
    cmp("stop_busy", int'(busy), 0);
    cmp("stop_done", int'(done), 0);

    // clear mid-run at q=3, then restart
    period = 4'd7; mode_reload = 1'b0; start = 1'b1;
    cyc(); start = 1'b0;
    cyc(); cyc(); cyc();
    cmp("pre_clr_q", int'(q), 3);
    clear = 1'b1;
    cyc(); clear = 1'b0;
    cmp("clr_q", int'(q), 0);
    cmp("clr_busy", int'(busy), 0);
    cmp("clr_tc", int'(tc), 0);
    period = 4'd2; start = 1'b1;
    cyc(); start = 1'b0;
    cmp("restart_busy", int'(busy), 1);
    cyc(); cyc();
    cmp("restart_tc", int'(tc), 1);
    cyc();
    cmp("restart_done", int'(done), 1);
    cyc();

    // period 0 rejected; with stop, silently ignored
    period = 4'd0; start = 1'b1;
    cyc(); start = 1'b0;
    cmp("err_pulse", int'(err), 1);
    cmp("err_busy", int'(busy), 0);
    cyc();
    cmp("err_clears", int'(err), 0);
    start = 1'b1; stop = 1'b1;
    cyc();
    cmp("err_stop_err", int'(err), 0);
    period = 4'd4;
    cyc(); start = 1'b0; stop = 1'b0;
    cmp("ss_busy", int'(busy), 0);
    cmp("ss_err", int'(err), 0);

    // full-scale period 15
    period = 4'd15; start = 1'b1;
    cyc(); start = 1'b0;
    for (int i = 0; i < 15; i++) cyc();
    cmp("max_q", int'(q), 15);
    cmp("max_tc", int'(tc), 1);
    cyc();
    cmp("max_done", int'(done), 1);
    cmp("max_done_q", int'(q), 15);
    cyc();

`ifdef COUNTER_SEQUENCER_PAUSE_EN
    period = 4'd4; mode_reload = 1'b0; start = 1'b1;
    cyc(); start = 1'b0;
    cyc(); cyc();
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      cmp("pause_q", int'(q), 2);
    end
    pause = 1'b0;
    cyc(); cmp("resume_q3", int'(q), 3);
    cyc(); cmp("resume_q4", int'(q), 4);
    pause = 1'b1;
    cyc(); cyc();
    cmp("pause_tc_done", int'(done), 0);
    cmp("pause_tc_busy", int'(busy), 1);
    pause = 1'b0;
    cyc();
    cmp("pause_rel_done", int'(done), 1);
    cyc();
    start = 1'b1;
    cyc(); start = 1'b0;
    pause = 1'b1; stop = 1'b1;
    cyc(); pause = 1'b0; stop = 1'b0;
    cmp("pause_stop_busy", int'(busy), 0);
    cyc();
`endif

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
Synchronous control block that sequences a WIDTH-bit up-counter through programmable count periods. It accepts start/stop commands, counts from 0 to a latched terminal value, flags terminal count, and either stops (one-shot) or reloads (periodic). It sits between the system control logic and the counter datapath and replaces free-running counters wherever a bounded, restartable count is needed.

Parameters:
WIDTH, 4, counter and period width in bits (legal range 2..16)

Ports:
clk  input  1  system clock; all state updates on rising edge
clear  input  1  synchronous, active-high reset
start  input  1  command: begin a count sequence (sampled in IDLE only)
stop  input  1  command: abort the running sequence
mode_reload  input  1  0 = one-shot, 1 = periodic reload; sampled with start
period  input  WIDTH  terminal count value; sampled with start
q  output  WIDTH  current count value (registered)
busy  output  1  high while in RUN
tc  output  1  terminal count flag, high while RUN and q == latched period
done  output  1  one-cycle pulse at one-shot completion
err  output  1  one-cycle pulse when start is rejected because period == 0

Behaviour:
- Single clock domain. Reset is synchronous, active-high: clear=1 at a rising edge forces IDLE, q=0, busy=0, done=0, err=0, period_r=0, mode_r=0. tc=0 follows from the state. clear overrides every other input, including mid-RUN.
- States: IDLE, RUN, DONE. State is held in a binary-encoded register.
- IDLE: q holds its last value.
  - start=1, stop=0, period!=0 -> next state RUN. period_r<=period, mode_r<=mode_reload, q<=0, busy<=1.
  - start=1, period==0 -> stay in IDLE. err=1 for exactly one cycle. q unchanged.
  - start=1 and stop=1 together -> stop wins. Stay in IDLE with no err.
- RUN: each edge q<=q+1 until q==period_r. tc is combinational: state==RUN and q==period_r.
  - At the edge where tc=1 with mode_r=1: q<=0 and state stays RUN. Period of tc pulses = period_r+1 cycles.
  - At the edge where tc=1 with mode_r=0: state<=DONE, q holds period_r, busy<=0.
  - stop=1 at any edge in RUN -> state<=IDLE, q holds its current value, busy<=0, no done pulse. stop has priority over reload and completion. tc still reflects q in the stop cycle.
  - start in RUN is ignored. Changes on period or mode_reload in RUN have no effect.
- DONE: done=1 for this single cycle, busy=0, q=period_r. Next edge goes to IDLE unconditionally. start and stop are ignored in DONE.
- Latency: start edge -> busy=1 and q=0 in the next cycle. One-shot: busy high for period_r+1 cycles, then done for 1 cycle.
- Width rules: period_r <= 2^WIDTH-1. q never exceeds period_r and so never overflows. Increment is modulo-free.
- All outputs except tc are registered.

Optional Feature:
COUNTER_SEQUENCER_PAUSE_EN
- Defined: adds input port pause (1 bit).
  - In RUN with pause=1 and stop=0: q holds, state holds, no reload or completion occurs even if tc=1, and busy stays 1.
  - stop overrides pause.
  - pause has no effect in IDLE or DONE.
- Undefined: the pause port is absent and RUN counts unconditionally.

Test Plan:
- Reset: drive clear=1 mid-RUN (q=3) -> next cycle q=0, busy=0, tc=0, done=0, state IDLE. start on the following cycle is accepted normally.
- One-shot: period=5, mode_reload=0, start pulse -> q=0,1,2,3,4,5 on successive cycles, busy high 6 cycles, tc high only when q=5, done pulses once with q=5, then IDLE.
- Periodic: period=3, mode_reload=1 -> q cycles 0,1,2,3,0,1,... and tc pulses every 4 cycles. stop at q=2 -> IDLE with q=2, no done.
- Boundaries: period=0 with start -> err one cycle, busy stays 0. Period=15 (WIDTH=4) -> q reaches 15 without wrap, done pulses. start and stop together in IDLE -> no state change.
- Command filtering: start asserted in RUN and in DONE -> ignored, no relatch. Change period mid-RUN from 5 to 2 -> terminal stays at 5.
- With COUNTER_SEQUENCER_PAUSE_EN: period=4, pause=1 for 3 cycles at q=2 -> q holds at 2, then resumes 3,4. pause=1 at q=4 -> no completion until pause drops. pause with stop -> IDLE.
